// File: rtl/dac_spi_tx_if.sv
// Sample-side handshake plus DAC pin bundle for dac_spi_tx.
// The transmitter connects through the slave modport, the sample source through master.
interface dac_spi_tx_if;
    logic        i_valid;
    logic [15:0] i_sample;
    logic        o_ready;
    logic        o_sclk;
    logic        o_sync_n;
    logic        o_sdata;
    logic        o_done;
    logic        o_drop;

    modport master (
        output i_valid, i_sample,
        input  o_ready, o_sclk, o_sync_n, o_sdata, o_done, o_drop
    );

    modport slave (
        input  i_valid, i_sample,
        output o_ready, o_sclk, o_sync_n, o_sdata, o_done, o_drop
    );
endinterface

// File: rtl/dac_spi_tx.sv
// Shifts one 16-bit sample per frame, MSB first, to a SYNC_n/SCLK/DIN DAC.
// SCLK idles high; data changes only on rising SCLK so it is stable at every falling edge.
module dac_spi_tx #(
    parameter int CLK_DIV    = 2,
    parameter int GAP_CYCLES = 4,
    parameter int SIGNED_IN  = 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    dac_spi_tx_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t           state_q;
    logic [DIV_W-1:0] div_q;
    logic [3:0]       bit_q;
    logic [GAP_W-1:0] gap_q;
    logic [15:0]      word_q;
    logic             sclk_q;
    logic             sync_n_q;
    logic             sdata_q;
    logic             done_q;
    logic             drop_q;

    logic [15:0]      word_d;
    logic             tick_d;

    // Offset-binary conversion of a two's-complement sample is just an MSB flip.
    assign word_d = (SIGNED_IN != 0) ? {~bus.i_sample[15], bus.i_sample[14:0]} : bus.i_sample;
    assign tick_d = (div_q == DIV_LAST);

    assign bus.o_ready  = (state_q == IDLE);
    assign bus.o_sclk   = sclk_q;
    assign bus.o_sync_n = sync_n_q;
    assign bus.o_sdata  = sdata_q;
    assign bus.o_done   = done_q;
    assign bus.o_drop   = drop_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            div_q    <= '0;
            bit_q    <= '0;
            gap_q    <= '0;
            word_q   <= '0;
            sclk_q   <= 1'b1;
            sync_n_q <= 1'b1;
            sdata_q  <= 1'b0;
            done_q   <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            drop_q <= bus.i_valid && (state_q != IDLE);
            case (state_q)
                IDLE: begin
                    if (bus.i_valid) begin
                        word_q   <= word_d;
                        sdata_q  <= word_d[15];
                        sync_n_q <= 1'b0;
                        sclk_q   <= 1'b1;
                        div_q    <= '0;
                        bit_q    <= 4'd15;
                        state_q  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (tick_d) begin
                        div_q <= '0;
                        if (sclk_q) begin
                            sclk_q <= 1'b0;
                        end else if (bit_q != 4'd0) begin
                            sclk_q  <= 1'b1;
                            bit_q   <= bit_q - 4'd1;
                            sdata_q <= word_q[bit_q - 4'd1];
                        end else begin
                            // Rising edge after the 16th falling edge closes the frame.
                            sclk_q   <= 1'b1;
                            sync_n_q <= 1'b1;
                            sdata_q  <= 1'b0;
                            done_q   <= 1'b1;
                            gap_q    <= '0;
                            state_q  <= (GAP_CYCLES == 0) ? IDLE : GAP;
                        end
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                GAP: begin
                    if (gap_q == GAP_LAST) begin
                        state_q <= IDLE;
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dac_spi_tx.sv
// Directed bench for dac_spi_tx: three instances (unsigned, signed, fast/no-gap) each watched
// by a DAC receiver model that samples DIN on falling SCLK while SYNC_n is low.
module tb_dac_spi_tx;
    typedef struct {
        int done_n;
        int drop_n;
        int low_len;
        int t_done;
        int t_rdy;
    } mon_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dac_spi_tx_if bus [3] ();

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dac_spi_tx #(
            .CLK_DIV    ((g == 2) ? 1 : 2),
            .GAP_CYCLES ((g == 2) ? 0 : 4),
            .SIGNED_IN  ((g == 1) ? 1 : 0)
        ) u_dut (
            .i_clk   (clk),
            .i_rst_n (rst_n),
            .bus     (bus[g])
        );

        mon_t        m = '{default: 0};
        logic [15:0] sr = '0;
        int          bits = 0;
        logic        sclk_p = 1'b1;
        logic        sync_p = 1'b1;
        logic        rdy_p = 1'b1;
        logic [15:0] rxq [$];

        // Outputs are sampled mid-cycle, so an SCLK fall shows up as 1 -> 0 between samples.
        always @(negedge clk) begin
            sclk_p <= bus[g].o_sclk;
            sync_p <= bus[g].o_sync_n;
            rdy_p  <= bus[g].o_ready;
            if (!bus[g].o_sync_n) begin
                if (sync_p) begin
                    sr        <= '0;
                    bits      <= 0;
                    m.low_len <= 1;
                end else begin
                    m.low_len <= m.low_len + 1;
                    if (sclk_p && !bus[g].o_sclk) begin
                        sr   <= {sr[14:0], bus[g].o_sdata};
                        bits <= bits + 1;
                    end
                end
            end else if (!sync_p && bits == 16) begin
                rxq.push_back(sr);
            end
            if (bus[g].o_done) begin
                m.done_n <= m.done_n + 1;
                m.t_done <= cyc;
            end
            if (bus[g].o_drop) m.drop_n <= m.drop_n + 1;
            if (bus[g].o_ready && !rdy_p) m.t_rdy <= cyc;
        end
    end

    function automatic mon_t mon(input int g);
        case (g)
            0:       return g_dut[0].m;
            1:       return g_dut[1].m;
            default: return g_dut[2].m;
        endcase
    endfunction

    function automatic int rxn(input int g);
        case (g)
            0:       return g_dut[0].rxq.size();
            1:       return g_dut[1].rxq.size();
            default: return g_dut[2].rxq.size();
        endcase
    endfunction

    function automatic logic [31:0] rx(input int g, input int i);
        logic [15:0] q [$];
        case (g)
            0:       q = g_dut[0].rxq;
            1:       q = g_dut[1].rxq;
            default: q = g_dut[2].rxq;
        endcase
        if (i < q.size()) return {16'h0000, q[i]};
        return 32'hDEAD_BEEF;
    endfunction

    function automatic logic rdy(input int g);
        case (g)
            0:       return bus[0].o_ready;
            1:       return bus[1].o_ready;
            default: return bus[2].o_ready;
        endcase
    endfunction

    task automatic drive(input int g, input logic v, input logic [15:0] s);
        case (g)
            0:       begin bus[0].i_valid = v; bus[0].i_sample = s; end
            1:       begin bus[1].i_valid = v; bus[1].i_sample = s; end
            default: begin bus[2].i_valid = v; bus[2].i_sample = s; end
        endcase
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns the cycle stamp of the first cycle after the accept edge (A+1).
    task automatic send(input int g, input logic [15:0] s, output int c);
        drive(g, 1'b1, s);
        @(negedge clk);
        c = cyc;
        drive(g, 1'b0, 16'h0000);
    endtask

    task automatic wait_ready(input int g, input string tag);
        int n = 0;
        while (!rdy(g) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_ready"}, {31'b0, rdy(g)}, 32'd1);
        @(negedge clk);
    endtask

    initial begin
        int c, c2, n, n0, d0, p0;

        rst_n = 1'b0;
        for (int g = 0; g < 3; g++) drive(g, 1'b0, 16'h0000);

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_ready",  {31'b0, bus[0].o_ready},  32'd1);
        chk("rst_sclk",   {31'b0, bus[0].o_sclk},   32'd1);
        chk("rst_sync_n", {31'b0, bus[0].o_sync_n}, 32'd1);
        chk("rst_sdata",  {31'b0, bus[0].o_sdata},  32'd0);
        chk("rst_done",   {31'b0, bus[0].o_done},   32'd0);
        chk("rst_drop",   {31'b0, bus[0].o_drop},   32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Unsigned frame with timing
        send(0, 16'hA5C3, c);
        drive(0, 1'b0, 16'h0F0F);
        chk("a5_first_sync", {31'b0, bus[0].o_sync_n}, 32'd0);
        chk("a5_first_bit",  {31'b0, bus[0].o_sdata},  32'd1);
        chk("a5_ready_low",  {31'b0, bus[0].o_ready},  32'd0);
        wait_ready(0, "a5");
        chk("a5_data",    rx(0, 0), 32'h0000_A5C3);
        chk("a5_low_len", mon(0).low_len, 32'd64);
        chk("a5_t_done",  mon(0).t_done, c + 64);
        chk("a5_t_rdy",   mon(0).t_rdy, c + 68);
        chk("a5_done_n",  mon(0).done_n, 32'd1);

        // Signed input -> offset binary
        send(1, 16'h8000, c);
        wait_ready(1, "s8000");
        send(1, 16'h7FFF, c);
        wait_ready(1, "s7fff");
        send(1, 16'h0000, c);
        wait_ready(1, "s0000");
        chk("s8000_data", rx(1, 0), 32'h0000_0000);
        chk("s7fff_data", rx(1, 1), 32'h0000_FFFF);
        chk("s0000_data", rx(1, 2), 32'h0000_8000);

        // Continuous valid with incrementing sample
        n0 = rxn(0);
        d0 = mon(0).done_n;
        p0 = mon(0).drop_n;
        for (int k = 0; k < 276; k++) begin
            drive(0, 1'b1, 16'(k));
            @(negedge clk);
        end
        drive(0, 1'b0, 16'h0000);
        wait_ready(0, "stream");
        chk("stream_f0",   rx(0, n0),     32'd0);
        chk("stream_f1",   rx(0, n0 + 1), 32'd69);
        chk("stream_f2",   rx(0, n0 + 2), 32'd138);
        chk("stream_f3",   rx(0, n0 + 3), 32'd207);
        chk("stream_nfr",  rxn(0) - n0, 32'd4);
        chk("stream_done", mon(0).done_n - d0, 32'd4);
        chk("stream_drop", mon(0).drop_n - p0, 32'd272);

        // Single stray valid mid-frame
        n0 = rxn(0);
        d0 = mon(0).done_n;
        p0 = mon(0).drop_n;
        send(0, 16'h1234, c);
        repeat (32) @(negedge clk);
        drive(0, 1'b1, 16'hBEEF);
        @(negedge clk);
        drive(0, 1'b0, 16'h0000);
        wait_ready(0, "stray");
        chk("stray_drop", mon(0).drop_n - p0, 32'd1);
        chk("stray_data", rx(0, n0), 32'h0000_1234);
        chk("stray_done", mon(0).done_n - d0, 32'd1);

        // Reset mid-frame, then a normal frame
        n0 = rxn(0);
        d0 = mon(0).done_n;
        send(0, 16'h5A5A, c);
        repeat (32) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_sync_n", {31'b0, bus[0].o_sync_n}, 32'd1);
        chk("mid_rst_sclk",   {31'b0, bus[0].o_sclk},   32'd1);
        chk("mid_rst_sdata",  {31'b0, bus[0].o_sdata},  32'd0);
        chk("mid_rst_ready",  {31'b0, bus[0].o_ready},  32'd1);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("mid_rst_no_done",  mon(0).done_n - d0, 32'd0);
        chk("mid_rst_no_frame", rxn(0) - n0, 32'd0);
        send(0, 16'h00FF, c);
        wait_ready(0, "after_rst");
        chk("after_rst_data", rx(0, n0), 32'h0000_00FF);

        // CLK_DIV=1, no gap: back-to-back frames
        drive(2, 1'b1, 16'hFFFF);
        @(negedge clk);
        c = cyc;
        drive(2, 1'b1, 16'h0001);
        n = 0;
        while (!rdy(2) && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        c2 = cyc;
        drive(2, 1'b0, 16'h0000);
        chk("fast_period", c2 - c, 32'd33);
        wait_ready(2, "fast");
        chk("fast_low_len", mon(2).low_len, 32'd32);
        chk("fast_t_done",  mon(2).t_done, c2 + 32);
        chk("fast_ffff",    rx(2, 0), 32'h0000_FFFF);
        chk("fast_0001",    rx(2, 1), 32'h0000_0001);
        chk("fast_done_n",  mon(2).done_n, 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
